// File: rtl/sha512_lane_dispatch_pkg.sv
// Shared types and lane-selection helper for the multi-lane SHA-512 dispatcher.
package sha512_lane_dispatch_pkg;

  localparam int unsigned SHA512_MAX_LANES = 16;

  typedef logic [511:0] t_block;
  typedef logic [3:0]   t_lane_id;

  typedef enum logic {
    DISP_IDLE,
    DISP_STREAM
  } t_dispatch_state;

  // First free lane at or after ptr, wrapping at nLanes; returns ptr when none is free.
  function automatic t_lane_id pickLane(input logic [SHA512_MAX_LANES-1:0] freeMask,
                                        input t_lane_id ptr,
                                        input int unsigned nLanes);
    int unsigned idx;
    logic        found;
    pickLane = ptr;
    found    = 1'b0;
    for (int unsigned k = 0; k < SHA512_MAX_LANES; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= nLanes) idx = idx - nLanes;
      if ((k < nLanes) && !found && freeMask[idx[3:0]]) begin
        pickLane = t_lane_id'(idx);
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sha512_lane_dispatch_if.sv
// Requestor block stream and in-order digest return channel of the lane dispatcher.
interface sha512_lane_dispatch_if;
  import sha512_lane_dispatch_pkg::*;

  t_block [1:0] in_block;
  logic         in_valid;
  logic         in_first;
  logic         in_last;
  logic         in_ready;
  t_block       out_digest;
  logic         out_digest_valid;
  logic         out_digest_ready;

  modport master (
    output in_block, in_valid, in_first, in_last, out_digest_ready,
    input  in_ready, out_digest, out_digest_valid
  );

  modport slave (
    input  in_block, in_valid, in_first, in_last, out_digest_ready,
    output in_ready, out_digest, out_digest_valid
  );
endinterface

// File: rtl/sha512_lane_dispatch_order_fifo.sv
// Message-arrival order FIFO of lane ids; head names the lane whose digest is returned next.
module sha512_lane_dispatch_order_fifo
  import sha512_lane_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push,
  input  logic     pop,
  input  t_lane_id pushId,
  output t_lane_id head,
  output logic     full,
  output logic     empty
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  t_lane_id        mem [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   count;
  logic            doPush, doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[rdPtr];
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushId;
        wrPtr      <= nextPtr(wrPtr);
      end
      if (doPop) rdPtr <= nextPtr(rdPtr);
      if (doPush && !doPop)      count <= count + CW'(1);
      else if (doPop && !doPush) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/sha512_lane_dispatch.sv
// Round-robin SHA-512 lane dispatcher with in-order digest return.
// Optional SHA512_DISPATCH_PERF_EN adds saturating perf_blocks/perf_msgs/perf_stall counters.
module sha512_lane_dispatch
  import sha512_lane_dispatch_pkg::*;
#(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned PERF_W  = 48
) (
  input  logic                clk,
  input  logic                reset_n,
  sha512_lane_dispatch_if.slave bus,
  output t_block [1:0]        lane_block [N_LANES],
  output logic [N_LANES-1:0]  lane_block_valid,
  input  logic [N_LANES-1:0]  lane_ready,
  input  t_block              lane_digest [N_LANES],
  input  logic [N_LANES-1:0]  lane_digest_valid,
  output logic                busy,
  output logic                err_proto
`ifdef SHA512_DISPATCH_PERF_EN
  ,
  output logic [PERF_W-1:0]   perf_blocks,
  output logic [PERF_W-1:0]   perf_msgs,
  output logic [PERF_W-1:0]   perf_stall
`endif
);
  if (N_LANES < 1 || N_LANES > SHA512_MAX_LANES || PERF_W < 1) begin : gBadParams
    $error("sha512_lane_dispatch: parameter out of range");
  end

  t_dispatch_state              state, stateNext;
  t_lane_id                     curLane, rrPtr, pick, head;
  logic [N_LANES-1:0]           laneBusy, digV, fwdMask, claimMask, popMask;
  t_block                       digR [N_LANES];
  logic [SHA512_MAX_LANES-1:0]  freeMask;
  logic                         fifoFull, fifoEmpty, headValid;
  logic                         curReady, curPending, inReady, xfer, push, pop;

  sha512_lane_dispatch_order_fifo #(.DEPTH(N_LANES)) uOrderFifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .pushId (pick),
    .head   (head),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // Lane muxes: current streaming lane and the lane at the head of the order FIFO.
  always_comb begin
    freeMask               = '0;
    freeMask[N_LANES-1:0]  = ~laneBusy;
    curReady               = 1'b0;
    curPending             = 1'b0;
    headValid              = 1'b0;
    bus.out_digest         = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (curLane == t_lane_id'(i)) begin
        curReady   = lane_ready[i];
        curPending = lane_block_valid[i];
      end
      if (head == t_lane_id'(i)) begin
        bus.out_digest = digR[i];
        headValid      = digV[i];
      end
    end
    inReady = (state == DISP_IDLE) ? ((|freeMask) & ~fifoFull) : (curReady & ~curPending);
  end

  assign pick                 = pickLane(freeMask, rrPtr, N_LANES);
  assign bus.in_ready         = inReady & reset_n;
  assign xfer                 = bus.in_valid & bus.in_ready;
  assign push                 = xfer & bus.in_first & (state == DISP_IDLE);
  assign bus.out_digest_valid = ~fifoEmpty & headValid;
  assign pop                  = bus.out_digest_valid & bus.out_digest_ready;
  assign busy                 = (|laneBusy) | (|digV);

  always_comb begin
    for (int unsigned i = 0; i < N_LANES; i++) begin
      claimMask[i] = push & (pick == t_lane_id'(i));
      fwdMask[i]   = claimMask[i] | (xfer & (state == DISP_STREAM) & (curLane == t_lane_id'(i)));
      popMask[i]   = pop & (head == t_lane_id'(i));
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      DISP_IDLE:   if (push && !bus.in_last) stateNext = DISP_STREAM;
      DISP_STREAM: if (xfer && bus.in_last)  stateNext = DISP_IDLE;
      default:     stateNext = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= DISP_IDLE;
    else          state <= stateNext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrPtr            <= '0;
      curLane          <= '0;
      laneBusy         <= '0;
      digV             <= '0;
      lane_block_valid <= '0;
      err_proto        <= 1'b0;
      for (int unsigned i = 0; i < N_LANES; i++) begin
        lane_block[i] <= '0;
        digR[i]       <= '0;
      end
    end else begin
      lane_block_valid <= '0;
      // Capture is applied after pop so a same-cycle digest on the head lane stays valid.
      for (int unsigned i = 0; i < N_LANES; i++) begin
        if (fwdMask[i]) begin
          lane_block[i]       <= bus.in_block;
          lane_block_valid[i] <= 1'b1;
        end
        if (claimMask[i]) laneBusy[i] <= 1'b1;
        if (popMask[i]) begin
          laneBusy[i] <= 1'b0;
          digV[i]     <= 1'b0;
        end
        if (lane_digest_valid[i]) begin
          digR[i] <= lane_digest[i];
          digV[i] <= 1'b1;
        end
      end
      if (push) begin
        curLane <= pick;
        rrPtr   <= (pick == t_lane_id'(N_LANES - 1)) ? '0 : pick + 4'd1;
      end
      if ((xfer && (state == DISP_IDLE) && !bus.in_first) ||
          (xfer && (state == DISP_STREAM) && bus.in_first) ||
          (|(lane_digest_valid & digV)))
        err_proto <= 1'b1;
    end
  end

`ifdef SHA512_DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_blocks <= '0;
      perf_msgs   <= '0;
      perf_stall  <= '0;
    end else begin
      if (xfer && (perf_blocks != '1)) perf_blocks <= perf_blocks + PERF_W'(1);
      if (pop && (perf_msgs != '1))    perf_msgs   <= perf_msgs + PERF_W'(1);
      if (bus.in_valid && !bus.in_ready && (perf_stall != '1))
        perf_stall <= perf_stall + PERF_W'(1);
    end
  end
`endif

endmodule
